// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target responder: frame lengths, the
// positions of the frame fields and the frame FSM state encoding.
package spi_target_pkg;

   localparam int CFG_LEN     = 64;
   localparam int DAC_LEN     = 32;

   localparam int W_BIT       = 63;
   localparam int ADDR_HI     = 62;
   localparam int ADDR_LO     = 59;
   localparam int PAR_BIT     = 58;
   localparam int DAC_PAR_BIT = 31;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SHIFT  = 3'd1,
      COMMIT = 3'd2,
      WAIT   = 3'd3,
      ABORT  = 3'd4
   } state_e;

   // Status word returned in the first half of every config frame.
   function automatic logic [31:0] status_word(input logic [15:0] frame_cnt,
                                               input logic [7:0]  abort_cnt,
                                               input logic        last_abort);
      return {frame_cnt, abort_cnt, 7'b0, last_abort};
   endfunction

endpackage

// File: rtl/spi_target_shift.sv
// Serial front end of the SPI target: counts received bits, collects MOSI
// into a 64-bit shift register (newest bit at [0]) and drives MISO from a
// 32-bit load/shift register (MSB out first). Load wins over shift; clear
// wins over both so MISO rests at 0 outside of frame shifting.
module spi_target_shift (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        shift_en,
   input  logic        mosi,
   input  logic        load,
   input  logic [31:0] load_word,
   input  logic        out_clr,
   output logic [6:0]  cnt,
   output logic [63:0] in_sr,
   output logic        miso
);

   logic [6:0]  cnt_q, cnt_d;
   logic [63:0] in_sr_q, in_sr_d;
   logic [31:0] out_sr_q, out_sr_d;

   // Next-state of the bit counter and both shift registers.
   always_comb begin
      cnt_d    = cnt_q;
      in_sr_d  = in_sr_q;
      out_sr_d = out_sr_q;
      if (start) begin
         cnt_d = 7'd1;
      end else if (shift_en) begin
         cnt_d = cnt_q + 7'd1;
      end
      if (start || shift_en) begin
         in_sr_d = {in_sr_q[62:0], mosi};
      end
      if (out_clr) begin
         out_sr_d = '0;
      end else if (load) begin
         out_sr_d = load_word;
      end else if (shift_en) begin
         out_sr_d = {out_sr_q[30:0], 1'b0};
      end
   end

   // Counter and MISO register are cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q    <= '0;
         out_sr_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         out_sr_q <= out_sr_d;
      end
   end

   // Received bits carry no state of their own; they are not reset.
   always_ff @(posedge clk) begin
      in_sr_q <= in_sr_d;
   end

   assign cnt   = cnt_q;
   assign in_sr = in_sr_q;
   assign miso  = out_sr_q[31];

endmodule

// File: rtl/spi_target_resp.sv
// SPI target responder. Decodes 64-bit config frames into a register file
// (status word + pre-write readback returned on MISO) and 32-bit DAC frames
// into a shadow code that DACSYNC commits to dac_code.
// Optional build macro: SPI_PARITY_EN enables even-parity checking of config
// (bit 58) and DAC (bit 31) frames; without it parity_err is tied 0.
module spi_target_resp
   import spi_target_pkg::*;
#(
   parameter int NREG  = 8,
   parameter int DAC_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_b,
   input  logic              spi_sel,
   input  logic              mosi,
   input  logic              dacsync,
   output logic              miso,
   output logic [NREG*32-1:0] cfg_flat,
   output logic              cfg_wr,
   output logic [DAC_W-1:0]  dac_code,
   output logic              dac_pend,
   output logic              parity_err
);

   localparam int AW = $clog2(NREG);

   state_e             state_q;
   logic               sel_q, sel_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic               armed_q, armed_d;
   logic [NREG*32-1:0] cfg_q, cfg_d;
   logic               cfg_wr_q, cfg_wr_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic [7:0]         abort_cnt_q, abort_cnt_d;
   logic               last_abort_q, last_abort_d;
   logic               par_err_q, par_err_d;
   logic [DAC_W-1:0]   shadow_q, shadow_d;
   logic [DAC_W-1:0]   dac_code_q, dac_code_d;
   logic               dac_pend_q, dac_pend_d;

   logic               start, shift_en, load, out_clr;
   logic [31:0]        load_word, rd_word;
   logic [6:0]         cnt, len_last;
   logic [63:0]        in_sr;
   logic [AW+4:0]      rd_base, wr_base;
   logic               cfg_par_ok, dac_par_ok;

   spi_target_shift u_shift (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .shift_en  (shift_en),
      .mosi      (mosi),
      .load      (load),
      .load_word (load_word),
      .out_clr   (out_clr),
      .cnt       (cnt),
      .in_sr     (in_sr),
      .miso      (miso)
   );

`ifdef SPI_PARITY_EN
   assign cfg_par_ok = ~^{in_sr[W_BIT:PAR_BIT], in_sr[31:0]};
   assign dac_par_ok = ~^{in_sr[DAC_PAR_BIT], in_sr[DAC_W-1:0]};
   assign parity_err = par_err_q;
   logic unused_bits;
   assign unused_bits = ^in_sr;
`else
   assign cfg_par_ok = 1'b1;
   assign dac_par_ok = 1'b1;
   assign parity_err = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{in_sr, par_err_q};
`endif

   // Front-end control decode: a frame starts only after cs_b has been seen
   // high since reset, so a select left low across reset is not decoded.
   always_comb begin
      start     = (state_q == IDLE) && !cs_b && armed_q;
      shift_en  = (state_q == SHIFT) && !cs_b;
      len_last  = sel_q ? 7'(DAC_LEN - 1) : 7'(CFG_LEN - 1);
      rd_base   = {addr_q, 5'b0};
      rd_word   = cfg_q[rd_base +: 32];
      load      = start || (shift_en && !sel_q && (cnt == 7'd32));
      out_clr   = !(start || shift_en);
      if (start) begin
         load_word = spi_sel ? 32'(shadow_q)
                             : status_word(frame_cnt_q, abort_cnt_q, last_abort_q);
      end else begin
         load_word = rd_word;
      end
   end

   // Frame FSM: collect LEN bits, apply for one cycle, then wait for deselect.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_q <= SHIFT;
            SHIFT: begin
               if (cs_b) begin
                  state_q <= ABORT;
               end else if (cnt == len_last) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT:  state_q <= WAIT;
            WAIT:    if (cs_b) state_q <= IDLE;
            ABORT:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Frame application, counters and the DAC double buffer.
   always_comb begin
      sel_d        = sel_q;
      addr_d       = addr_q;
      armed_d      = armed_q | cs_b;
      cfg_d        = cfg_q;
      cfg_wr_d     = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      abort_cnt_d  = abort_cnt_q;
      last_abort_d = last_abort_q;
      par_err_d    = 1'b0;
      shadow_d     = shadow_q;
      dac_code_d   = dac_code_q;
      dac_pend_d   = dac_pend_q;
      wr_base      = {in_sr[ADDR_LO +: AW], 5'b0};

      if (start) begin
         sel_d = spi_sel;
      end
      // After five bits the address field sits at in_sr[3:0].
      if (shift_en && !sel_q && (cnt == 7'd5)) begin
         addr_d = in_sr[AW-1:0];
      end

      // Commit strobe moves the old shadow out before a same-cycle reload.
      if (dacsync && dac_pend_q) begin
         dac_code_d = shadow_q;
         dac_pend_d = 1'b0;
      end

      if (state_q == COMMIT) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
         if (sel_q) begin
            if (dac_par_ok) begin
               shadow_d   = in_sr[DAC_W-1:0];
               dac_pend_d = 1'b1;
            end else begin
               par_err_d = 1'b1;
            end
         end else begin
            last_abort_d = 1'b0;
            if (!cfg_par_ok) begin
               par_err_d = 1'b1;
            end else if (in_sr[W_BIT]) begin
               cfg_d[wr_base +: 32] = in_sr[31:0];
               cfg_wr_d             = 1'b1;
            end
         end
      end

      if (state_q == ABORT) begin
         last_abort_d = 1'b1;
         if (abort_cnt_q != 8'hFF) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
         end
      end
   end

   // Architectural state, all cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         armed_q      <= 1'b0;
         cfg_q        <= '0;
         cfg_wr_q     <= 1'b0;
         frame_cnt_q  <= '0;
         abort_cnt_q  <= '0;
         last_abort_q <= 1'b0;
         par_err_q    <= 1'b0;
         shadow_q     <= '0;
         dac_code_q   <= '0;
         dac_pend_q   <= 1'b0;
      end else begin
         armed_q      <= armed_d;
         cfg_q        <= cfg_d;
         cfg_wr_q     <= cfg_wr_d;
         frame_cnt_q  <= frame_cnt_d;
         abort_cnt_q  <= abort_cnt_d;
         last_abort_q <= last_abort_d;
         par_err_q    <= par_err_d;
         shadow_q     <= shadow_d;
         dac_code_q   <= dac_code_d;
         dac_pend_q   <= dac_pend_d;
      end
   end

   // Per-frame latches; only meaningful while a frame is in flight.
   always_ff @(posedge clk) begin
      sel_q  <= sel_d;
      addr_q <= addr_d;
   end

   assign cfg_flat = cfg_q;
   assign cfg_wr   = cfg_wr_q;
   assign dac_code = dac_code_q;
   assign dac_pend = dac_pend_q;

endmodule

// File: tb/tb_spi_target_resp.sv
// Directed bench for spi_target_resp: config write/read, abort, DAC double
// buffering, reset mid-frame and (with SPI_PARITY_EN) parity rejection.
module tb_spi_target_resp;

   localparam int NREG  = 8;
   localparam int DAC_W = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               cs_b = 1'b1;
   logic               spi_sel = 1'b0;
   logic               mosi = 1'b0;
   logic               dacsync = 1'b0;
   logic               miso;
   logic [NREG*32-1:0] cfg_flat;
   logic               cfg_wr;
   logic [DAC_W-1:0]   dac_code;
   logic               dac_pend;
   logic               parity_err;

   int n_checks = 0;
   int n_errs   = 0;
   int wr_cnt   = 0;
   int perr_cnt = 0;

   logic [NREG*32-1:0] exp_cfg = '0;
   logic [63:0]        resp;

   spi_target_resp #(.NREG(NREG), .DAC_W(DAC_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cs_b       (cs_b),
      .spi_sel    (spi_sel),
      .mosi       (mosi),
      .dacsync    (dacsync),
      .miso       (miso),
      .cfg_flat   (cfg_flat),
      .cfg_wr     (cfg_wr),
      .dac_code   (dac_code),
      .dac_pend   (dac_pend),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cfg_wr === 1'b1) wr_cnt++;
      if (parity_err === 1'b1) perr_cnt++;
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] cfg_frame(input logic w, input logic [3:0] addr,
                                             input logic [31:0] data, input logic bad_par);
      logic [63:0] f;
      f = {w, addr, 27'b0, data};
`ifdef SPI_PARITY_EN
      f[58] = (^{f[63:59], f[31:0]}) ^ bad_par;
`else
      f[58] = f[58] | (bad_par & 1'b0);
`endif
      return f;
   endfunction

   function automatic logic [63:0] dac_frame(input logic [15:0] code);
      logic [63:0] f;
      f = {48'b0, code};
`ifdef SPI_PARITY_EN
      f[31] = ^code;
`endif
      return f;
   endfunction

   // Shifts nbits of a frame (MSB first) and collects MISO. Response bit k
   // is visible after the edge that takes MOSI bit k. Ends with cs_b high
   // and the responder back in IDLE.
   task automatic send(input logic sel, input int nbits, input logic [63:0] frm,
                       input logic sync_at_commit, output logic [63:0] r);
      int len;
      len = sel ? 32 : 64;
      r = '0;
      for (int k = 0; k < nbits; k++) begin
         @(negedge clk);
         if (k > 0) r[len-k] = miso;
         cs_b    = 1'b0;
         spi_sel = sel;
         mosi    = frm[len-1-k];
      end
      @(negedge clk);
      if (nbits == len) r[0] = miso;
      dacsync = sync_at_commit;
      cs_b    = 1'b1;
      mosi    = 1'b0;
      @(negedge clk);
      dacsync = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // Reset
      repeat (3) @(negedge clk);
      chk("rst_miso", 256'(miso), 256'(0));
      chk("rst_cfg", cfg_flat, '0);
      chk("rst_dac", 256'({cfg_wr, dac_code, dac_pend, parity_err}), 256'(0));
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Write reg3, then read it back
      send(1'b0, 64, cfg_frame(1'b1, 4'd3, 32'hDEADBEEF, 1'b0), 1'b0, resp);
      exp_cfg[3*32 +: 32] = 32'hDEADBEEF;
      chk("wr3_resp", 256'(resp), 256'(64'h0000_0000_0000_0000));
      chk("wr3_cfg", cfg_flat, exp_cfg);
      chk("wr3_pulses", 256'(wr_cnt), 256'(1));

      send(1'b0, 64, cfg_frame(1'b0, 4'd3, 32'h0, 1'b0), 1'b0, resp);
      chk("rd3_resp", 256'(resp), 256'(64'h0001_0000_DEAD_BEEF));
      chk("rd3_cfg", cfg_flat, exp_cfg);
      chk("rd3_pulses", 256'(wr_cnt), 256'(1));

      // Address upper bit ignored: 0xE selects reg6
      send(1'b0, 64, cfg_frame(1'b1, 4'hE, 32'h1234_5678, 1'b0), 1'b0, resp);
      exp_cfg[6*32 +: 32] = 32'h1234_5678;
      chk("wrE_resp", 256'(resp), 256'(64'h0002_0000_0000_0000));
      chk("wrE_cfg", cfg_flat, exp_cfg);

      // Abort after 40 bits of a write to reg1
      send(1'b0, 40, cfg_frame(1'b1, 4'd1, 32'hCAFE_F00D, 1'b0), 1'b0, resp);
      chk("abort_cfg", cfg_flat, exp_cfg);
      chk("abort_pulses", 256'(wr_cnt), 256'(2));
      send(1'b0, 64, cfg_frame(1'b0, 4'd1, 32'h0, 1'b0), 1'b0, resp);
      chk("abort_status", 256'(resp), 256'(64'h0003_0101_0000_0000));
      send(1'b0, 64, cfg_frame(1'b0, 4'd3, 32'h0, 1'b0), 1'b0, resp);
      chk("abort_clear", 256'(resp), 256'(64'h0004_0100_DEAD_BEEF));

      // DAC frame, commit 5 cycles later
      send(1'b1, 32, dac_frame(16'h1234), 1'b0, resp);
      chk("dac1_echo", 256'(resp[31:0]), 256'(0));
      chk("dac1_pend", 256'({dac_code, dac_pend}), 256'({16'h0000, 1'b1}));
      repeat (4) @(negedge clk);
      chk("dac1_hold", 256'({dac_code, dac_pend}), 256'({16'h0000, 1'b1}));
      dacsync = 1'b1;
      @(negedge clk);
      dacsync = 1'b0;
      chk("dac1_sync", 256'({dac_code, dac_pend}), 256'({16'h1234, 1'b0}));

      // Second DAC frame with dacsync on its COMMIT cycle
      send(1'b1, 32, dac_frame(16'h5678), 1'b1, resp);
      chk("dac2_echo", 256'(resp[31:0]), 256'(32'h0000_1234));
      chk("dac2_pend", 256'({dac_code, dac_pend}), 256'({16'h1234, 1'b1}));
      dacsync = 1'b1;
      @(negedge clk);
      dacsync = 1'b0;
      chk("dac2_sync", 256'({dac_code, dac_pend}), 256'({16'h5678, 1'b0}));
      @(negedge clk);
      dacsync = 1'b1;
      @(negedge clk);
      dacsync = 1'b0;
      chk("dac_nopend", 256'({dac_code, dac_pend}), 256'({16'h5678, 1'b0}));

      send(1'b0, 64, cfg_frame(1'b0, 4'd0, 32'h0, 1'b0), 1'b0, resp);
      chk("dac_framecnt", 256'(resp), 256'(64'h0007_0100_0000_0000));

      // Reset at bit 30 of a write, cs_b left low across and after reset
      begin
         logic [63:0] f;
         f = cfg_frame(1'b1, 4'd2, 32'hA5A5_A5A5, 1'b0);
         for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            cs_b = 1'b0;
            spi_sel = 1'b0;
            mosi = f[63-k];
         end
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_cfg = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         mosi = k[0];
      end
      chk("rstmid_miso", 256'(miso), 256'(0));
      @(negedge clk);
      cs_b = 1'b1;
      mosi = 1'b0;
      repeat (2) @(negedge clk);
      chk("rstmid_cfg", cfg_flat, '0);
      chk("rstmid_dac", 256'({dac_code, dac_pend}), 256'(0));
      chk("rstmid_pulses", 256'(wr_cnt), 256'(2));
      send(1'b0, 64, cfg_frame(1'b0, 4'd2, 32'h0, 1'b0), 1'b0, resp);
      chk("rstmid_status", 256'(resp), 256'(64'h0));
      send(1'b0, 64, cfg_frame(1'b1, 4'd2, 32'h0BAD_F00D, 1'b0), 1'b0, resp);
      exp_cfg[2*32 +: 32] = 32'h0BAD_F00D;
      send(1'b0, 64, cfg_frame(1'b0, 4'd2, 32'h0, 1'b0), 1'b0, resp);
      chk("rstmid_rd", 256'(resp), 256'(64'h0002_0000_0BAD_F00D));
      chk("rstmid_cfg2", cfg_flat, exp_cfg);

`ifdef SPI_PARITY_EN
      // Bad parity suppresses the write but still counts the frame
      send(1'b0, 64, cfg_frame(1'b1, 4'd5, 32'h55AA_1234, 1'b1), 1'b0, resp);
      chk("par_bad_cfg", cfg_flat, exp_cfg);
      chk("par_bad_pulse", 256'(perr_cnt), 256'(1));
      chk("par_bad_wr", 256'(wr_cnt), 256'(3));
      send(1'b0, 64, cfg_frame(1'b0, 4'd5, 32'h0, 1'b0), 1'b0, resp);
      chk("par_bad_status", 256'(resp), 256'(64'h0004_0000_0000_0000));
      send(1'b0, 64, cfg_frame(1'b1, 4'd5, 32'h55AA_1234, 1'b0), 1'b0, resp);
      exp_cfg[5*32 +: 32] = 32'h55AA_1234;
      send(1'b0, 64, cfg_frame(1'b0, 4'd5, 32'h0, 1'b0), 1'b0, resp);
      chk("par_good_rd", 256'(resp), 256'(64'h0006_0000_55AA_1234));
      chk("par_good_cfg", cfg_flat, exp_cfg);
      chk("par_good_pulse", 256'(perr_cnt), 256'(1));
`else
      chk("par_tied0", 256'(perr_cnt), 256'(0));
`endif

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
